// File: rtl/cache_refill_controller.sv
// Refill/write-through controller between a CPU, a direct-mapped one-word-line cache and main memory.
// Optional hit/miss statistics ports are enabled with the CACHE_STATS_EN macro.
module cache_refill_controller #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic                  cache_we,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  input  logic                  cache_hit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    MEM_WRITE,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic                  rd_q, rd_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      fill_q  <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    fill_d      = fill_q;
    rd_d        = rd_q;
    stall       = 1'b0;
    cpu_rdata   = '0;
    cache_addr  = addr_q;
    cache_wdata = data_q;
    cache_we    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = addr_q;
    mem_wdata   = data_q;

    case (state_q)
      IDLE: begin
        cache_addr = cpu_addr;
        // A store takes priority; a simultaneous load request is ignored.
        if (cpu_we) begin
          stall       = 1'b1;
          cache_we    = 1'b1;
          cache_wdata = cpu_wdata;
          addr_d      = cpu_addr;
          data_d      = cpu_wdata;
          rd_d        = 1'b0;
          state_d     = MEM_WRITE;
        end else if (cpu_re) begin
          if (cache_hit) begin
            cpu_rdata = cache_rdata;
          end else begin
            stall   = 1'b1;
            addr_d  = cpu_addr;
            rd_d    = 1'b1;
            state_d = MEM_READ;
          end
        end
      end
      MEM_READ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          fill_d  = mem_rdata;
          state_d = DONE;
        end
      end
      MEM_WRITE: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rd_q) begin
          cache_we    = 1'b1;
          cache_wdata = fill_q;
          cpu_rdata   = fill_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic        hit_ev, miss_ev;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  assign hit_ev  = (state_q == IDLE) && cpu_re && !cpu_we && cache_hit;
  assign miss_ev = (state_q == IDLE) && cpu_re && !cpu_we && !cache_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_ev && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_ev && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_refill_controller.sv
// Scoreboard bench for cache_refill_controller with a behavioural cache and directed memory acks.
module tb_cache_refill_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_re, cpu_we, stall;
  logic [31:0] cache_addr, cache_wdata, cache_rdata;
  logic        cache_we, cache_hit;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_hits = 0;
  int unsigned exp_miss = 0;
  logic [31:0] sb[$];

  cache_refill_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_we(cache_we),
    .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Direct-mapped, one-word-line cache model indexed by address bits [7:2].
  logic [31:0] ctag[64];
  logic [31:0] cdat[64];
  logic        cval[64];

  always_comb begin
    cache_hit   = cval[cache_addr[7:2]] && (ctag[cache_addr[7:2]] == cache_addr);
    cache_rdata = cache_hit ? cdat[cache_addr[7:2]] : 32'hBAD0_BAD0;
  end

  always @(posedge clk) begin
    if (cache_we) begin
      cval[cache_addr[7:2]] <= 1'b1;
      ctag[cache_addr[7:2]] <= cache_addr;
      cdat[cache_addr[7:2]] <= cache_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completed load is checked against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && cpu_re && !cpu_we && !stall) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL load_unexpected: got 0x%08h expected no load completion at %0t", cpu_rdata, $time);
      end else begin
        chk("load_rdata", cpu_rdata, sb.pop_front());
      end
    end
  end

  // k = 0 expects a hit; k >= 1 acks on the k-th MEM_READ cycle.
  task automatic do_load(input logic [31:0] a, input logic [31:0] exp, input int k,
                         input logic [31:0] mdata);
    int   st   = 0;
    int   reqs = 0;
    int   cyc  = 0;
    logic done = 1'b0;
    @(posedge clk); #1;
    cpu_addr = a;
    cpu_re   = 1'b1;
    sb.push_back(exp);
    if (k == 0) exp_hits++; else exp_miss++;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (mem_req) begin
        reqs++;
        chk("rd_mem_addr", mem_addr, a);
        chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
        if (reqs == k) begin
          mem_ack   = 1'b1;
          mem_rdata = mdata;
        end
      end
      if (stall) st++;
      else begin
        done = 1'b1;
        if (k != 0) begin
          chk("fill_cache_we", {31'd0, cache_we}, 32'd1);
          chk("fill_cache_wdata", cache_wdata, exp);
          chk("fill_cache_addr", cache_addr, a);
        end
      end
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = 32'h5A5A_5A5A;
    end
    cpu_re = 1'b0;
    chk("load_done", {31'd0, done}, 32'd1);
    chk("load_stall_cycles", st, (k == 0) ? 32'd0 : k + 1);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int k,
                          input logic both);
    int   st   = 0;
    int   reqs = 0;
    int   cyc  = 0;
    logic done = 1'b0;
    @(posedge clk); #1;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_we    = 1'b1;
    cpu_re    = both;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("st_cache_we", {31'd0, cache_we}, 32'd1);
        chk("st_cache_wdata", cache_wdata, d);
        chk("st_cache_addr", cache_addr, a);
      end
      if (mem_req) begin
        reqs++;
        chk("st_mem_we", {31'd0, mem_we}, 32'd1);
        chk("st_mem_addr", mem_addr, a);
        chk("st_mem_wdata", mem_wdata, d);
        if (reqs == k) mem_ack = 1'b1;
      end
      if (stall) st++;
      else begin
        done = 1'b1;
        chk("st_done_cache_we", {31'd0, cache_we}, 32'd0);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    cpu_we = 1'b0;
    cpu_re = 1'b0;
    chk("st_done", {31'd0, done}, 32'd1);
    chk("st_stall_cycles", st, k + 1);
    chk("st_mem_req_cycles", reqs, k);
  endtask

  task automatic idle_quiet(input string name);
    @(negedge clk);
    chk({name, "_cache_we"}, {31'd0, cache_we}, 32'd0);
    chk({name, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({name, "_stall"}, {31'd0, stall}, 32'd0);
    chk({name, "_cpu_rdata"}, cpu_rdata, 32'd0);
  endtask

  task automatic chk_stats();
`ifdef CACHE_STATS_EN
    @(negedge clk);
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_miss);
`endif
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 64; i++) cval[i] = 1'b0;
    rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_re = 1'b0; cpu_we = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_cache_we", {31'd0, cache_we}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_load(32'h40, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF);
    do_load(32'h40, 32'hDEAD_BEEF, 0, 32'h0);
    do_store(32'h44, 32'h1234_5678, 1, 1'b0);
    do_load(32'h44, 32'h1234_5678, 0, 32'h0);
    do_store(32'h48, 32'hCAFE_F00D, 2, 1'b1);
    do_load(32'h48, 32'hCAFE_F00D, 0, 32'h0);
    do_load(32'h4C, 32'h0BAD_F00D, 1, 32'h0BAD_F00D);
    chk_stats();

    // Spurious ack while idle.
    @(posedge clk); #1;
    mem_ack = 1'b1;
    idle_quiet("spur_ack");
    @(posedge clk); #1;
    mem_ack = 1'b0;
    idle_quiet("spur_after");

    // Reset in the middle of a read miss, then a late ack.
    @(posedge clk); #1;
    cpu_addr = 32'h80;
    cpu_re   = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && seen < 2; c++) begin
      @(negedge clk);
      if (mem_req) seen++;
    end
    chk("rst_case_mem_read_cycles", seen, 32'd2);
    @(posedge clk); #1;
    rst = 1'b1; cpu_re = 1'b0; cpu_addr = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
    idle_quiet("post_rst");
    @(posedge clk); #1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_1111;
    idle_quiet("late_ack");
    @(posedge clk); #1;
    mem_ack = 1'b0;
    idle_quiet("late_ack_after");

    do_load(32'h80, 32'h8080_8080, 2, 32'h8080_8080);
    chk_stats();

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
